wide_sync_capture_controller: RTL and testbench
===============================================

Name: wide_sync_capture_controller

Overview:
Destination-domain controller for a wide double-flop synchronizer bus. It detects a synchronized request toggle from the source domain and enables the wide synchronizer only while a transfer is in flight. It captures the bus only after it has been bit-stable for SETTLE_CYCLES consecutive cycles, presents the word on a valid/ready interface, and returns an acknowledge toggle. A stability timeout makes sure a glitching bus never deadlocks the four-phase-free toggle protocol.

Parameters:
WIDTH, 8, width of the synchronized data bus (>=1)
SETTLE_CYCLES, 2, consecutive equal samples required before capture (>=1)
TIMEOUT_CYCLES, 16, maximum SETTLE-state cycles before abandoning the transfer (> SETTLE_CYCLES+1)

Ports:
clk  input  1  destination-domain clock
rst  input  1  reset; synchronous, active-high
req_toggle_sync  input  1  source request toggle, already passed through a single-bit synchronizer
sync_enable  output  1  enable to the wide synchronizer instance
sync_data  input  WIDTH  output of the wide synchronizer
out_data  output  WIDTH  captured word
out_valid  output  1  captured word available
out_ready  input  1  consumer accepts out_data
ack_toggle  output  1  acknowledge toggle to the source domain (source synchronizes it)
timeout_pulse  output  1  one-cycle pulse when a transfer is abandoned as unstable

Behaviour:
- State encoding lives in the package: IDLE, SETTLE, PRESENT.
- Reset values: state=IDLE, req_seen=0, ack_toggle=0, out_valid=0, out_data=0, sync_enable=0, timeout_pulse=0, and all counters and sample registers 0.
- Reset is honoured in any state. A transfer in flight is dropped without toggling ack.
- IDLE:
  - New request when req_toggle_sync != req_seen.
  - On that cycle: req_seen <= req_toggle_sync, elapsed <= 0, stable_cnt <= 0, first <= 1, go to SETTLE.
  - sync_enable=0 in IDLE.
- SETTLE:
  - sync_enable=1, decoded from the registered state.
  - Each cycle: sample_q <= sync_data, elapsed++.
  - A cycle is a match if first==0 and sync_data==sample_q. On the first cycle, first clears and the cycle counts as no match.
  - On a match, stable_cnt++; otherwise stable_cnt <= 0.
  - Capture when the current cycle matches and stable_cnt==SETTLE_CYCLES-1, or immediately for SETTLE_CYCLES==1 on any match.
  - On capture: out_data <= sync_data, out_valid <= 1, go to PRESENT.
  - If elapsed==TIMEOUT_CYCLES-1 and there is no capture on that cycle: timeout_pulse <= 1 for one cycle, ack_toggle flips (the source is released and will retry), go to IDLE, out_valid stays 0.
  - Capture takes priority over timeout on the same cycle.
- PRESENT:
  - out_valid=1; out_data is held constant; sync_enable=0.
  - On out_valid && out_ready: out_valid <= 0, ack_toggle flips, go to IDLE.
  - The consumer may stall indefinitely; there is no timeout in PRESENT.
- Latency with a constant bus and SETTLE_CYCLES=2:
  - request seen in IDLE at cycle T;
  - SETTLE at T+1 (first sample), T+2 (match, cnt=1), T+3 (match, capture);
  - out_valid=1 from T+4.
  - With out_ready held high, ack_toggle flips at T+5.
- Further request toggles while in SETTLE or PRESENT are not lost. req_seen compares against the last accepted value, so a pending toggle is accepted on the first IDLE cycle after return. Two toggles (net no change) are indistinguishable from none; the source protocol forbids issuing a new request before ack.
- The minimum gap between transfers is one IDLE cycle.
- Counter widths: $clog2(TIMEOUT_CYCLES) for elapsed and $clog2(SETTLE_CYCLES+1) for stable_cnt. Comparisons are unsigned, with no wrap (elapsed never exceeds TIMEOUT_CYCLES-1).

Decomposition:
- Package wide_sync_capture_pkg holds:
  - the state enum typedef (IDLE/SETTLE/PRESENT);
  - localparam helpers for the counter widths.
- Natural sub-module: sync_stability_detector. Inputs: clk, rst, start, data. Output: stable pulse after N consecutive equal samples. It owns sample_q, first and stable_cnt.
- The top module holds the FSM, timeout counter, output registers and toggle logic.
- The wide synchronizer is instantiated by the parent, not inside this block.

Test Plan:
- Reset then idle: rst high 3 cycles, req_toggle_sync=0 -> all outputs 0; no sync_enable for 20 cycles.
- Clean transfer: sync_data=8'hA5 constant, req toggles 0->1 at T, out_ready=1 -> sync_enable high T+1..T+3; out_valid and out_data=A5 at T+4; ack_toggle=1 at T+5.
- Backpressure: same as the clean transfer with out_ready=0 for 10 cycles -> out_valid held, out_data=A5 stable, ack unchanged; ack flips exactly one cycle after out_ready rises.
- Skewed bus: sync_data alternates 3C/C3 for 4 SETTLE cycles then holds 3C -> capture 3C only after 2 consecutive matches; no timeout_pulse.
- Timeout: sync_data toggles every cycle, TIMEOUT_CYCLES=16 -> exactly one timeout_pulse at the 16th SETTLE cycle; ack flips; out_valid never asserts; state returns to IDLE.
- Back-to-back and reset mid-transfer: second req toggle arrives during PRESENT -> accepted on the first IDLE cycle after ack. rst asserted during SETTLE -> next cycle all outputs at reset values, ack_toggle=0.

Source files
------------

// File: rtl/wide_sync_capture_pkg.sv
// Shared state encoding and counter-width helpers for the wide synchronizer capture controller.
package wide_sync_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    function automatic int elapsed_width(input int timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

    function automatic int stable_width(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_stability_detector.sv
// Flags a bus that has held the same value for SETTLE_CYCLES consecutive sample-to-sample matches.
// Combinational stable output in the matching cycle; no backpressure (samples whenever active).
module sync_stability_detector
    import wide_sync_capture_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic [WIDTH-1:0] data,
    output logic             stable
);

    localparam int CW = stable_width(SETTLE_CYCLES);

    logic [WIDTH-1:0] sample_q;
    logic             first;
    logic [CW-1:0]    stable_cnt;
    logic             match;

    // The first sample after start has nothing valid to compare against.
    assign match  = !first && (data == sample_q);
    assign stable = active && match && (stable_cnt == CW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q   <= '0;
            first      <= 1'b0;
            stable_cnt <= '0;
        end else if (start) begin
            first      <= 1'b1;
            stable_cnt <= '0;
        end else if (active) begin
            sample_q <= data;
            first    <= 1'b0;
            if (match) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/wide_sync_capture_controller.sv
// Toggle-request capture of a wide synchronized bus once stable; out_valid 4 cycles after request (SETTLE_CYCLES=2).
// Holds the word under out_ready backpressure indefinitely; ack toggles on handshake or on stability timeout.
module wide_sync_capture_controller
    import wide_sync_capture_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_toggle_sync,
    output logic             sync_enable,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ack_toggle,
    output logic             timeout_pulse
);

    localparam int EW = elapsed_width(TIMEOUT_CYCLES);

    state_t        state;
    state_t        state_nxt;
    logic          req_seen;
    logic [EW-1:0] elapsed;
    logic          new_req;
    logic          start;
    logic          stable;
    logic          capture;
    logic          expire;
    logic          handshake;

    assign new_req     = (req_toggle_sync != req_seen);
    assign start       = (state == IDLE) && new_req;
    assign sync_enable = (state == SETTLE);

    sync_stability_detector #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_detector (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .active (sync_enable),
        .data   (sync_data),
        .stable (stable)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        expire    = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (new_req) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // A capture on the last allowed cycle beats the timeout.
                if (stable) begin
                    capture   = 1'b1;
                    state_nxt = PRESENT;
                end else if (elapsed == EW'(TIMEOUT_CYCLES - 1)) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESENT: begin
                if (out_valid && out_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_seen      <= 1'b0;
            elapsed       <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            ack_toggle    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            timeout_pulse <= expire;
            if (start) begin
                req_seen <= req_toggle_sync;
                elapsed  <= '0;
            end else if (sync_enable && !capture && !expire) begin
                elapsed <= elapsed + 1'b1;
            end
            if (capture) begin
                out_data  <= sync_data;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
            // The source is released either way; after a timeout it retries.
            if (expire || handshake) begin
                ack_toggle <= ~ack_toggle;
            end
        end
    end

endmodule

// File: tb/tb_wide_sync_capture_controller.sv
// Scenario bench for wide_sync_capture_controller with a run-length reference model of bus stability.
module tb_wide_sync_capture_controller;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;
    localparam int TO     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_toggle_sync;
    logic             sync_enable;
    logic [WIDTH-1:0] sync_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             ack_toggle;
    logic             timeout_pulse;

    int   tests = 0;
    int   fails = 0;
    logic req_val = 1'b0;
    logic exp_ack = 1'b0;
    logic [WIDTH-1:0] pat [TO];

    always #5 clk = ~clk;

    wide_sync_capture_controller #(
        .WIDTH          (WIDTH),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_toggle_sync (req_toggle_sync),
        .sync_enable     (sync_enable),
        .sync_data       (sync_data),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .ack_toggle      (ack_toggle),
        .timeout_pulse   (timeout_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_req();
        req_val         = ~req_val;
        req_toggle_sync = req_val;
    endtask

    // Index of the first SETTLE sample that closes a run of SETTLE+1 equal samples
    // within the timeout window, or -1 when the bus never holds long enough.
    function automatic int predict_k();
        for (int i = SETTLE; i < TO; i++) begin
            bit ok = 1'b1;
            for (int j = i - SETTLE; j < i; j++) begin
                if (pat[j] != pat[i]) ok = 1'b0;
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_toggle_sync = 1'b0; req_val = 1'b0;
        sync_data = '0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({sync_enable, out_valid, ack_toggle, timeout_pulse, out_data} !== '0) begin
                fails++;
                $display("FAIL reset_outputs c=%0d got en=%b vld=%b ack=%b to=%b dat=%h want all 0",
                         c, sync_enable, out_valid, ack_toggle, timeout_pulse, out_data);
            end
        end
        rst = 1'b0; exp_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sync_data = WIDTH'($urandom);
            step();
            tests++;
            if ({sync_enable, out_valid, ack_toggle, timeout_pulse} !== 4'b0) begin
                fails++;
                $display("FAIL idle_quiet c=%0d got en=%b vld=%b ack=%b to=%b want 0",
                         c, sync_enable, out_valid, ack_toggle, timeout_pulse);
            end
        end
    endtask

    task automatic test_clean();
        sync_data = 8'hA5; out_ready = 1'b1;
        toggle_req();
        for (int s = 1; s <= 5; s++) begin
            step();
            tests++;
            if (sync_enable !== (s <= 3)) begin
                fails++; $display("FAIL clean_en s=%0d got %b want %b", s, sync_enable, s <= 3);
            end
            tests++;
            if (out_valid !== (s == 4)) begin
                fails++; $display("FAIL clean_vld s=%0d got %b want %b", s, out_valid, s == 4);
            end
            if (s == 4) begin
                tests++;
                if (out_data !== 8'hA5) begin
                    fails++; $display("FAIL clean_data got %h want a5", out_data);
                end
            end
            tests++;
            if (ack_toggle !== ((s == 5) ? ~exp_ack : exp_ack)) begin
                fails++; $display("FAIL clean_ack s=%0d got %b want %b", s, ack_toggle, (s == 5) ? ~exp_ack : exp_ack);
            end
        end
        exp_ack = ~exp_ack; out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        sync_data = 8'h77;
        toggle_req();
        for (int s = 1; s <= 2; s++) begin
            step();
            tests++;
            if (sync_enable !== 1'b1) begin
                fails++; $display("FAIL midrst_settle s=%0d got en=%b want 1", s, sync_enable);
            end
        end
        rst = 1'b1; req_val = 1'b0; req_toggle_sync = 1'b0;
        step();
        tests++;
        if ({sync_enable, out_valid, ack_toggle, timeout_pulse, out_data} !== '0) begin
            fails++;
            $display("FAIL midrst_outputs got en=%b vld=%b ack=%b to=%b dat=%h want all 0",
                     sync_enable, out_valid, ack_toggle, timeout_pulse, out_data);
        end
        rst = 1'b0; exp_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            tests++;
            if ({sync_enable, ack_toggle, timeout_pulse} !== 3'b0) begin
                fails++; $display("FAIL midrst_after c=%0d got en=%b ack=%b to=%b want 0",
                                  c, sync_enable, ack_toggle, timeout_pulse);
            end
        end
    endtask

    task automatic test_backpressure();
        sync_data = 8'hA5; out_ready = 1'b0;
        toggle_req();
        for (int s = 1; s <= 15; s++) begin
            step();
            out_ready = (s == 14);
            tests++;
            if (out_valid !== (s >= 4 && s <= 14)) begin
                fails++; $display("FAIL bp_vld s=%0d got %b want %b", s, out_valid, s >= 4 && s <= 14);
            end
            if (s >= 4 && s <= 14) begin
                tests++;
                if (out_data !== 8'hA5) begin
                    fails++; $display("FAIL bp_data s=%0d got %h want a5", s, out_data);
                end
            end
            tests++;
            if (ack_toggle !== ((s == 15) ? ~exp_ack : exp_ack)) begin
                fails++; $display("FAIL bp_ack s=%0d got %b want %b", s, ack_toggle, (s == 15) ? ~exp_ack : exp_ack);
            end
        end
        exp_ack = ~exp_ack; out_ready = 1'b0;
    endtask

    // Drives pat[] one sample per SETTLE cycle and checks every cycle against the model.
    task automatic run_pattern(input int stall, input string tag);
        int   k;
        int   last;
        logic exp_en;
        logic exp_vld;
        logic exp_to;
        logic exp_a;
        k    = predict_k();
        last = (k >= 0) ? k + 3 + stall : TO + 1;
        out_ready = 1'b0;
        toggle_req();
        for (int s = 1; s <= last; s++) begin
            step();
            if (s - 1 < TO) sync_data = pat[s-1];
            out_ready = (k >= 0) && (s == k + 2 + stall);
            exp_en  = (k >= 0) ? (s <= k + 1) : (s <= TO);
            exp_vld = (k >= 0) && (s >= k + 2) && (s <= k + 2 + stall);
            exp_to  = (k < 0) && (s == TO + 1);
            exp_a   = (s == last) ? ~exp_ack : exp_ack;
            tests++;
            if (sync_enable !== exp_en) begin
                fails++; $display("FAIL %s_en s=%0d got %b want %b", tag, s, sync_enable, exp_en);
            end
            tests++;
            if (out_valid !== exp_vld) begin
                fails++; $display("FAIL %s_vld s=%0d got %b want %b", tag, s, out_valid, exp_vld);
            end
            tests++;
            if (timeout_pulse !== exp_to) begin
                fails++; $display("FAIL %s_timeout s=%0d got %b want %b", tag, s, timeout_pulse, exp_to);
            end
            tests++;
            if (ack_toggle !== exp_a) begin
                fails++; $display("FAIL %s_ack s=%0d got %b want %b", tag, s, ack_toggle, exp_a);
            end
            if (exp_vld) begin
                tests++;
                if (out_data !== pat[k]) begin
                    fails++; $display("FAIL %s_data s=%0d got %h want %h", tag, s, out_data, pat[k]);
                end
            end
        end
        exp_ack = ~exp_ack; out_ready = 1'b0;
    endtask

    task automatic test_skew();
        for (int i = 0; i < TO; i++) pat[i] = (i < 4 && i % 2 == 1) ? 8'hC3 : 8'h3C;
        run_pattern(0, "skew");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TO; i++) pat[i] = (i % 2 == 1) ? 8'h55 : 8'hAA;
        run_pattern(0, "timeout");
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if ({sync_enable, out_valid, timeout_pulse} !== 3'b0) begin
                fails++; $display("FAIL timeout_idle c=%0d got en=%b vld=%b to=%b want 0",
                                  c, sync_enable, out_valid, timeout_pulse);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic a0;
        logic exp_en;
        logic exp_vld;
        logic exp_a;
        a0 = exp_ack;
        sync_data = 8'hA5; out_ready = 1'b0;
        toggle_req();
        for (int s = 1; s <= 12; s++) begin
            step();
            if (s == 4) toggle_req();
            if (s == 5) sync_data = 8'h5A;
            out_ready = (s == 6) || (s == 11);
            exp_en  = (s >= 1 && s <= 3) || (s >= 8 && s <= 10);
            exp_vld = (s >= 4 && s <= 6) || (s == 11);
            exp_a   = (s >= 7 && s <= 11) ? ~a0 : a0;
            tests++;
            if (sync_enable !== exp_en) begin
                fails++; $display("FAIL b2b_en s=%0d got %b want %b", s, sync_enable, exp_en);
            end
            tests++;
            if (out_valid !== exp_vld) begin
                fails++; $display("FAIL b2b_vld s=%0d got %b want %b", s, out_valid, exp_vld);
            end
            tests++;
            if (ack_toggle !== exp_a) begin
                fails++; $display("FAIL b2b_ack s=%0d got %b want %b", s, ack_toggle, exp_a);
            end
            if (exp_vld) begin
                tests++;
                if (out_data !== ((s <= 6) ? 8'hA5 : 8'h5A)) begin
                    fails++; $display("FAIL b2b_data s=%0d got %h want %h", s, out_data, (s <= 6) ? 8'hA5 : 8'h5A);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int p;
        for (int n = 0; n < 40; n++) begin
            p = int'($urandom_range(30, 95));
            pat[0] = WIDTH'($urandom);
            for (int i = 1; i < TO; i++) begin
                pat[i] = (int'($urandom_range(0, 99)) < p) ? pat[i-1] : WIDTH'($urandom_range(0, 3));
            end
            run_pattern(int'($urandom_range(0, 4)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_reset_mid();
        test_backpressure();
        test_skew();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
